// File: rtl/fault_alarm_if.sv
// Classifier-to-alarm bundle: classifier result and config inputs,
// alarm level, sticky IRQ and alarm status outputs.
//
// Parameters:
//   N_CLASS  number of classifier classes (class 0 is healthy), 2..16
//   CONF_W   confidence and threshold width
//   CNT_W    streak counter and count-config width
//
// Modports:
//   master  drives the classifier strobe, config and irq_ack,
//           and observes the alarm outputs
//   slave   the alarm controller side
interface fault_alarm_if #(
    parameter int N_CLASS = 4,
    parameter int CONF_W  = 8,
    parameter int CNT_W   = 4
);
    localparam int CLS_W = (N_CLASS > 2) ? $clog2(N_CLASS) : 1;

    logic               classification_done;
    logic [CLS_W-1:0]   class_id;
    logic [CONF_W-1:0]  confidence;
    logic [CONF_W-1:0]  alarm_threshold;
    logic [CNT_W-1:0]   fault_count_cfg;
    logic [CNT_W-1:0]   clear_count_cfg;
    logic [N_CLASS-1:0] class_mask;
    logic               irq_ack;

    logic               alarm_active;
    logic               alarm_irq;
    logic [CLS_W-1:0]   last_fault_class;
    logic [N_CLASS-1:0] alarm_class_vec;
    logic [CNT_W-1:0]   fault_streak;

    modport master (
        output classification_done, class_id, confidence,
        output alarm_threshold, fault_count_cfg, clear_count_cfg,
        output class_mask, irq_ack,
        input  alarm_active, alarm_irq, last_fault_class,
        input  alarm_class_vec, fault_streak
    );

    modport slave (
        input  classification_done, class_id, confidence,
        input  alarm_threshold, fault_count_cfg, clear_count_cfg,
        input  class_mask, irq_ack,
        output alarm_active, alarm_irq, last_fault_class,
        output alarm_class_vec, fault_streak
    );
endinterface

// File: rtl/fault_alarm_ctrl.sv
// Fault alarm controller: debounces classifier results into an alarm
// level with a sticky IRQ and a per-alarm set of faulting classes.
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous active-high reset
//   bus   fault_alarm_if.slave (classifier strobe, config, irq_ack in;
//         alarm_active, alarm_irq, last_fault_class, alarm_class_vec,
//         fault_streak out)
//
// Build option: define FAULT_ALARM_HYSTERESIS_EN to require
// clear_count_cfg consecutive healthy events before the alarm clears
// (CLEARING state). Without it the first healthy event in ALARM clears.
module fault_alarm_ctrl #(
    parameter int N_CLASS = 4,
    parameter int CONF_W  = 8,
    parameter int CNT_W   = 4
) (
    input logic          clk,
    input logic          rst,
    fault_alarm_if.slave bus
);
    localparam int CLS_W = (N_CLASS > 2) ? $clog2(N_CLASS) : 1;

    localparam logic [CLS_W:0]     N_CLS_V = (CLS_W + 1)'(N_CLASS);
    localparam logic [N_CLASS-1:0] VEC_ONE = {{(N_CLASS-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_HEALTHY,
        S_PENDING,
        S_ALARM,
        S_CLEARING
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   streak_q, streak_d;
    logic [CLS_W-1:0]   last_q, last_d;
    logic [N_CLASS-1:0] vec_q, vec_d;
    logic               irq_q, irq_d;
    logic               irq_set;

    logic               in_range;
    logic               qual;
    logic               healthy_ev;
    logic               fault_ev;
    logic [N_CLASS-1:0] cls_bit;
    logic               new_cls;
    logic [CNT_W-1:0]   eff_fault;
    logic [CNT_W-1:0]   streak_inc;
    logic [CNT_W-1:0]   pend_streak;

    // Out-of-range classes can only occur when N_CLASS is not a power of 2.
    assign in_range   = {1'b0, bus.class_id} < N_CLS_V;
    assign qual       = bus.classification_done && in_range &&
                        (bus.confidence >= bus.alarm_threshold);
    assign healthy_ev = qual && (bus.class_id == '0);
    assign fault_ev   = qual && (bus.class_id != '0) &&
                        bus.class_mask[bus.class_id];

    assign cls_bit   = VEC_ONE << bus.class_id;
    assign new_cls   = (vec_q & cls_bit) == '0;
    assign eff_fault = (bus.fault_count_cfg == '0) ? CNT_ONE
                                                   : bus.fault_count_cfg;

    assign streak_inc  = (streak_q == CNT_MAX) ? streak_q
                                               : streak_q + CNT_ONE;
    // A fault of a different class restarts the streak at that class.
    assign pend_streak = (bus.class_id == last_q) ? streak_inc : CNT_ONE;

`ifdef FAULT_ALARM_HYSTERESIS_EN
    logic [CNT_W-1:0] clr_q, clr_d;
    logic [CNT_W-1:0] eff_clear;
    logic [CNT_W-1:0] clr_inc;

    assign eff_clear = (bus.clear_count_cfg == '0) ? CNT_ONE
                                                   : bus.clear_count_cfg;
    assign clr_inc   = (clr_q == CNT_MAX) ? clr_q : clr_q + CNT_ONE;
`endif

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        last_d   = last_q;
        vec_d    = vec_q;
        irq_set  = 1'b0;
`ifdef FAULT_ALARM_HYSTERESIS_EN
        clr_d    = clr_q;
`endif
        unique case (state_q)
            S_HEALTHY: begin
                if (fault_ev) begin
                    streak_d = CNT_ONE;
                    last_d   = bus.class_id;
                    if (CNT_ONE >= eff_fault) begin
                        state_d = S_ALARM;
                        vec_d   = vec_q | cls_bit;
                        irq_set = 1'b1;
                    end else begin
                        state_d = S_PENDING;
                    end
                end
            end
            S_PENDING: begin
                if (fault_ev) begin
                    streak_d = pend_streak;
                    last_d   = bus.class_id;
                    // >= so a count lowered below the streak fires at once.
                    if (pend_streak >= eff_fault) begin
                        state_d = S_ALARM;
                        vec_d   = vec_q | cls_bit;
                        irq_set = 1'b1;
                    end
                end else if (healthy_ev) begin
                    streak_d = '0;
                    state_d  = S_HEALTHY;
                end
            end
            S_ALARM: begin
                if (fault_ev) begin
                    last_d  = bus.class_id;
                    vec_d   = vec_q | cls_bit;
                    irq_set = new_cls;
                end else if (healthy_ev) begin
`ifdef FAULT_ALARM_HYSTERESIS_EN
                    if (CNT_ONE >= eff_clear) begin
                        state_d  = S_HEALTHY;
                        vec_d    = '0;
                        streak_d = '0;
                        clr_d    = '0;
                    end else begin
                        state_d = S_CLEARING;
                        clr_d   = CNT_ONE;
                    end
`else
                    state_d  = S_HEALTHY;
                    vec_d    = '0;
                    streak_d = '0;
`endif
                end
            end
            S_CLEARING: begin
`ifdef FAULT_ALARM_HYSTERESIS_EN
                if (fault_ev) begin
                    state_d = S_ALARM;
                    clr_d   = '0;
                    last_d  = bus.class_id;
                    vec_d   = vec_q | cls_bit;
                    irq_set = new_cls;
                end else if (healthy_ev) begin
                    if (clr_inc >= eff_clear) begin
                        state_d  = S_HEALTHY;
                        vec_d    = '0;
                        streak_d = '0;
                        clr_d    = '0;
                    end else begin
                        clr_d = clr_inc;
                    end
                end
`else
                state_d = S_HEALTHY;
`endif
            end
            default: state_d = S_HEALTHY;
        endcase
        // A new set wins over an acknowledge in the same cycle.
        irq_d = (irq_q & ~bus.irq_ack) | irq_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_HEALTHY;
            streak_q <= '0;
            last_q   <= '0;
            vec_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            last_q   <= last_d;
            vec_q    <= vec_d;
            irq_q    <= irq_d;
        end
    end

`ifdef FAULT_ALARM_HYSTERESIS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_q <= '0;
        end else begin
            clr_q <= clr_d;
        end
    end
`endif

    assign bus.alarm_active     = (state_q == S_ALARM) ||
                                  (state_q == S_CLEARING);
    assign bus.alarm_irq        = irq_q;
    assign bus.last_fault_class = last_q;
    assign bus.alarm_class_vec  = vec_q;
    assign bus.fault_streak     = streak_q;
endmodule

// File: tb/tb_fault_alarm_ctrl.sv
// Bench for fault_alarm_ctrl: directed scenarios plus random events,
// every cycle compared against a behavioural alarm model.
module tb_fault_alarm_ctrl;
    localparam int NC   = 4;
    localparam int CMAX = 15;
`ifdef FAULT_ALARM_HYSTERESIS_EN
    localparam bit HYST = 1'b1;
`else
    localparam bit HYST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fault_alarm_if #(.N_CLASS(NC), .CONF_W(8), .CNT_W(4)) bus ();

    fault_alarm_ctrl #(.N_CLASS(NC), .CONF_W(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errs   = 0;
    int checks = 0;

    int       thr, fcfg, ccfg;
    bit [3:0] mask;

    bit       m_alarm, m_irq;
    int       m_streak, m_clr, m_last;
    bit [3:0] m_vec;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int eff(input int c);
        return (c == 0) ? 1 : c;
    endfunction

    function automatic int sat(input int c);
        return (c > CMAX) ? CMAX : c;
    endfunction

    task automatic model_reset();
        m_alarm  = 0;
        m_irq    = 0;
        m_streak = 0;
        m_clr    = 0;
        m_last   = 0;
        m_vec    = '0;
    endtask

    task automatic model_tick(input bit done, input int cid,
                              input int conf, input bit ack);
        bit set;
        set = 0;
        if (done && conf >= thr && cid < NC) begin
            if (cid != 0 && mask[cid]) begin
                if (!m_alarm) begin
                    if (m_streak > 0 && cid == m_last)
                        m_streak = sat(m_streak + 1);
                    else
                        m_streak = 1;
                    m_last = cid;
                    if (m_streak >= eff(fcfg)) begin
                        m_alarm    = 1;
                        m_vec[cid] = 1'b1;
                        set        = 1;
                    end
                end else begin
                    m_last = cid;
                    m_clr  = 0;
                    if (!m_vec[cid]) begin
                        m_vec[cid] = 1'b1;
                        set        = 1;
                    end
                end
            end else if (cid == 0) begin
                if (!m_alarm) begin
                    m_streak = 0;
                end else begin
                    m_clr = sat(m_clr + 1);
                    if (!HYST || m_clr >= eff(ccfg)) begin
                        m_alarm  = 0;
                        m_vec    = '0;
                        m_streak = 0;
                        m_clr    = 0;
                    end
                end
            end
        end
        m_irq = (m_irq && !ack) || set;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".active"}, int'(bus.alarm_active), int'(m_alarm));
        chk({tag, ".irq"}, int'(bus.alarm_irq), int'(m_irq));
        chk({tag, ".last"}, int'(bus.last_fault_class), m_last);
        chk({tag, ".vec"}, int'(bus.alarm_class_vec), int'(m_vec));
        chk({tag, ".streak"}, int'(bus.fault_streak), m_streak);
    endtask

    // Called just after a falling edge; drives one cycle, checks #1
    // after the rising edge, returns at the next falling edge.
    task automatic step(input string tag, input bit done, input int cid,
                        input int conf, input bit ack);
        bus.alarm_threshold     = 8'(thr);
        bus.fault_count_cfg     = 4'(fcfg);
        bus.clear_count_cfg     = 4'(ccfg);
        bus.class_mask          = mask;
        bus.classification_done = done;
        bus.class_id            = 2'(cid);
        bus.confidence          = 8'(conf);
        bus.irq_ack             = ack;
        @(posedge clk);
        model_tick(done, cid, conf, ack);
        #1;
        bus.classification_done = 1'b0;
        bus.irq_ack             = 1'b0;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.classification_done = 1'b0;
        bus.class_id            = '0;
        bus.confidence          = '0;
        bus.irq_ack             = 1'b0;
        thr  = 100;
        fcfg = 3;
        ccfg = 2;
        mask = 4'b1111;
        bus.alarm_threshold = 8'(thr);
        bus.fault_count_cfg = 4'(fcfg);
        bus.clear_count_cfg = 4'(ccfg);
        bus.class_mask      = mask;
        @(negedge clk);
        do_reset();

        // Three qualified class-1 faults raise the alarm.
        for (int i = 0; i < 3; i++) step("raise", 1, 1, 200, 0);
        chk("raise_active", int'(bus.alarm_active), 1);
        chk("raise_irq", int'(bus.alarm_irq), 1);
        chk("raise_last", int'(bus.last_fault_class), 1);

        // Low-confidence events change nothing.
        do_reset();
        for (int i = 0; i < 10; i++) step("lowconf", 1, 2, 50, 0);
        chk("lowconf_streak", int'(bus.fault_streak), 0);
        chk("lowconf_active", int'(bus.alarm_active), 0);

        // Healthy event breaks a streak; class change restarts it.
        do_reset();
        step("brk", 1, 3, 200, 0);
        step("brk", 1, 3, 200, 0);
        step("brk", 1, 0, 200, 0);
        step("brk", 1, 3, 200, 0);
        step("brk", 1, 3, 200, 0);
        chk("brk_streak", int'(bus.fault_streak), 2);
        chk("brk_active", int'(bus.alarm_active), 0);
        step("chg", 1, 1, 200, 0);
        step("chg", 1, 1, 200, 0);
        step("chg", 1, 2, 200, 0);
        chk("chg_streak", int'(bus.fault_streak), 1);
        chk("chg_last", int'(bus.last_fault_class), 2);

        // Class vector and IRQ re-arm; ack coinciding with a set.
        do_reset();
        fcfg = 1;
        step("vec", 1, 1, 200, 0);
        chk("vec_first", int'(bus.alarm_class_vec), 2);
        step("vec_ack", 0, 0, 0, 1);
        chk("vec_acked", int'(bus.alarm_irq), 0);
        step("vec", 1, 2, 200, 0);
        chk("vec_0110", int'(bus.alarm_class_vec), 6);
        chk("vec_irq", int'(bus.alarm_irq), 1);
        step("vec_ack", 0, 0, 0, 1);
        step("vec_race", 1, 3, 200, 1);
        chk("race_irq", int'(bus.alarm_irq), 1);

        // Clearing with a two-event healthy run.
        ccfg = 2;
        step("clr", 1, 0, 200, 0);
`ifdef FAULT_ALARM_HYSTERESIS_EN
        chk("clr_hold1", int'(bus.alarm_active), 1);
`else
        chk("clr_now", int'(bus.alarm_active), 0);
`endif
        step("clr", 1, 1, 200, 0);
        step("clr", 1, 0, 200, 0);
        step("clr", 1, 0, 200, 0);
        chk("clr_done", int'(bus.alarm_active), 0);
        chk("clr_vec", int'(bus.alarm_class_vec), 0);

        // Masked class never alarms; asynchronous reset mid-streak.
        do_reset();
        fcfg = 3;
        mask = 4'b1101;
        for (int i = 0; i < 5; i++) step("mask", 1, 1, 200, 0);
        chk("mask_active", int'(bus.alarm_active), 0);
        step("pend", 1, 2, 200, 0);
        step("pend", 1, 2, 200, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_active", int'(bus.alarm_active), 0);
        chk("arst_streak", int'(bus.fault_streak), 0);
        chk("arst_last", int'(bus.last_fault_class), 0);
        chk("arst_irq", int'(bus.alarm_irq), 0);
        chk("arst_vec", int'(bus.alarm_class_vec), 0);
        model_reset();
        @(negedge clk);
        rst  = 1'b0;
        mask = 4'b1111;
        fcfg = 1;
        step("first", 1, 3, 200, 0);
        chk("first_active", int'(bus.alarm_active), 1);

        // Random events, config changes, acks and resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                fcfg = $urandom_range(0, 4);
                ccfg = $urandom_range(0, 3);
                mask = 4'($urandom_range(0, 15));
                thr  = $urandom_range(0, 200);
            end
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step("rnd", $urandom_range(0, 3) != 0,
                     $urandom_range(0, 3), $urandom_range(0, 255),
                     $urandom_range(0, 5) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
